// File: rtl/microseq_pkg.sv
// Shared types and helpers for the microcode sequencer: internal state enum,
// the 2-bit externally visible state encoding and the page-width function.
package microseq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    BREAK = 3'd2,
    STEP  = 3'd3,
    HALT  = 3'd4
  } seq_state_e;

  localparam logic [1:0] STATE_OUT_IDLE  = 2'd0;
  localparam logic [1:0] STATE_OUT_RUN   = 2'd1;
  localparam logic [1:0] STATE_OUT_BREAK = 2'd2;
  localparam logic [1:0] STATE_OUT_HALT  = 2'd3;

  // max(1, clog2(n)) so a single-page build still has a 1-bit page field
  function automatic int page_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A single-step is reported as RUN to the outside world
  function automatic logic [1:0] encode_state(input seq_state_e s);
    logic [1:0] enc;
    enc = STATE_OUT_IDLE;
    case (s)
      IDLE:       enc = STATE_OUT_IDLE;
      RUN, STEP:  enc = STATE_OUT_RUN;
      BREAK:      enc = STATE_OUT_BREAK;
      HALT:       enc = STATE_OUT_HALT;
      default:    enc = STATE_OUT_IDLE;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/microseq_if.sv
// Control/ROM bundle between the microcode sequencer (slave) and the CPU
// side that drives run control, instruction state and the microcode ROM (master).
interface microseq_if
  import microseq_pkg::*;
#(
  parameter int OPCODE_W  = 8,
  parameter int FLAG_W    = 4,
  parameter int STEP_W    = 3,
  parameter int CWORD_W   = 32,
  parameter int EXT_PAGES = 2
);
  localparam int PAGE_W = page_w(EXT_PAGES);
  localparam int ADDR_W = PAGE_W + FLAG_W + OPCODE_W + STEP_W;

  logic                run;
  logic                cont_req;
  logic                step_req;
  logic                ctrlen;
  logic [OPCODE_W-1:0] opcode;
  logic [FLAG_W-1:0]   flags;
  logic [CWORD_W-1:0]  ucode;
  logic [ADDR_W-1:0]   uaddr;
  logic [CWORD_W-1:0]  control_word;
  logic [1:0]          state;
  logic [STEP_W-1:0]   step;
  logic [PAGE_W-1:0]   page;
  logic [31:0]         ustep_count;
  logic [31:0]         instr_count;

  modport master (
    output run, cont_req, step_req, ctrlen, opcode, flags, ucode,
    input  uaddr, control_word, state, step, page, ustep_count, instr_count
  );

  modport slave (
    input  run, cont_req, step_req, ctrlen, opcode, flags, ucode,
    output uaddr, control_word, state, step, page, ustep_count, instr_count
  );

endinterface

// File: rtl/microseq_stepctr.sv
// Microstep and extension-page registers with their priority update:
// instruction reset, page extension, natural wrap, increment.
module microseq_stepctr
  import microseq_pkg::*;
#(
  parameter int STEP_W    = 3,
  parameter int EXT_PAGES = 2,
  localparam int PAGE_W   = page_w(EXT_PAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec,
  input  logic              rstn,
  input  logic              extn,
  output logic [STEP_W-1:0] step,
  output logic [PAGE_W-1:0] page,
  output logic              instr_done
);

  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
  localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(EXT_PAGES - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [PAGE_W-1:0] page_q, page_d;

  always_comb begin
    step_d     = step_q;
    page_d     = page_q;
    instr_done = 1'b0;
    if (exec) begin
      if (!rstn) begin
        step_d     = '0;
        page_d     = '0;
        instr_done = 1'b1;
      end else if (!extn) begin
        step_d = '0;
        if (page_q != PAGE_MAX) page_d = page_q + 1'b1;
      end else if (step_q == STEP_MAX) begin
        step_d     = '0;
        page_d     = '0;
        instr_done = 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      page_q <= '0;
    end else begin
      step_q <= step_d;
      page_q <= page_d;
    end
  end

  assign step = step_q;
  assign page = page_q;

endmodule

// File: rtl/microseq.sv
// Microcode sequencer top: run/break/step/halt FSM, ROM address formation and
// control word gating. Define MICROSEQ_PERF_CNT_EN to build the step/instruction counters.
//
//   state | meaning
//   IDLE  | not sequencing, waiting for run or step_req
//   RUN   | one microstep executes per clock
//   BREAK | paused on a breakpoint, step held
//   STEP  | executes exactly one microstep, then back to BREAK
//   HALT  | frozen until reset
module microseq
  import microseq_pkg::*;
#(
  parameter int OPCODE_W  = 8,
  parameter int FLAG_W    = 4,
  parameter int STEP_W    = 3,
  parameter int CWORD_W   = 32,
  parameter int EXT_PAGES = 2,
  parameter int RSTN_BIT  = 0,
  parameter int EXTN_BIT  = 1,
  parameter int BRK_BIT   = 2,
  parameter int HLT_BIT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  microseq_if.slave   bus
);

  localparam int PAGE_W = page_w(EXT_PAGES);

  seq_state_e        state_q, state_d;
  logic              active;
  logic              instr_done;
  logic [STEP_W-1:0] step;
  logic [PAGE_W-1:0] page;
  logic              hlt, brk;

  assign active = (state_q == RUN) || (state_q == STEP);
  assign hlt    = bus.ucode[HLT_BIT];
  assign brk    = bus.ucode[BRK_BIT];

  microseq_stepctr #(
    .STEP_W    (STEP_W),
    .EXT_PAGES (EXT_PAGES)
  ) u_stepctr (
    .clk        (clk),
    .rst        (rst),
    .exec       (active),
    .rstn       (bus.ucode[RSTN_BIT]),
    .extn       (bus.ucode[EXTN_BIT]),
    .step       (step),
    .page       (page),
    .instr_done (instr_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.step_req)  state_d = STEP;
        else if (bus.run)  state_d = RUN;
      end
      RUN: begin
        if (hlt)           state_d = HALT;
        else if (brk)      state_d = BREAK;
        else if (!bus.run) state_d = IDLE;
      end
      BREAK: begin
        if (bus.cont_req)      state_d = RUN;
        else if (bus.step_req) state_d = STEP;
      end
      STEP: begin
        state_d = hlt ? HALT : BREAK;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign bus.uaddr        = {page, bus.flags, bus.opcode, step};
  assign bus.control_word = (active && bus.ctrlen) ? bus.ucode : '0;
  assign bus.state        = encode_state(state_q);
  assign bus.step         = step;
  assign bus.page         = page;

`ifdef MICROSEQ_PERF_CNT_EN
  logic [31:0] ustep_cnt_q, ustep_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    ustep_cnt_d = ustep_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (active)     ustep_cnt_d = ustep_cnt_q + 32'd1;
    if (instr_done) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ustep_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      ustep_cnt_q <= ustep_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.ustep_count = ustep_cnt_q;
  assign bus.instr_count = instr_cnt_q;
`else
  logic perf_unused;
  assign perf_unused     = instr_done;
  assign bus.ustep_count = '0;
  assign bus.instr_count = '0;
`endif

endmodule
